// File: rtl/dvp_pkg.sv
// Shared types and limits for the DVP capture path: FSM states, packer flags
// and the geometry check used at elaboration.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SKIP,
    ACTIVE,
    DROP
  } state_t;

  localparam int WORD_W     = 32;
  localparam int PIX_CNT_W  = 11;
  localparam int LINE_CNT_W = 10;
  localparam int SKIP_W     = 8;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  // Counter widths above bound the usable geometry.
  function automatic bit geometry_ok(input int img_w, input int img_h, input int skip_frames);
    return (img_w % 4 == 0) && (img_w >= 4) && (img_w < 2048) &&
           (img_h >= 1) && (img_h < 1024) &&
           (skip_frames >= 0) && (skip_frames < 256);
  endfunction

endpackage

// File: rtl/dvp_frame_capture_packer.sv
// Packs gray bytes four-per-word into a held output register with a
// valid/ready handshake; flags an overflow when a word completes while blocked.
module dvp_byte_packer
  import dvp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              sync,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  flags_t            flags,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              overflow
);

  logic [1:0]        idx;
  logic [WORD_W-9:0] shreg;
  logic [WORD_W-1:0] word_next;
  logic              word_done;
  logic              accept;

  assign word_next = {shreg, byte_in};
  assign word_done = byte_valid && (idx == 2'd3);
  assign accept    = m_valid && m_ready;
  assign overflow  = word_done && m_valid && !m_ready;

  // A word completing on the same edge as an acceptance simply replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      shreg   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (flush) begin
      idx     <= 2'd0;
      m_valid <= 1'b0;
    end else begin
      if (sync) begin
        idx <= 2'd0;
      end else if (byte_valid) begin
        idx   <= idx + 2'd1;
        shreg <= word_next[WORD_W-9:0];
      end
      if (word_done && !overflow) begin
        m_data  <= word_next;
        m_valid <= 1'b1;
        m_sof   <= flags.sof;
        m_eol   <= flags.eol;
        m_eof   <= flags.eof;
      end else if (accept) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dvp_frame_capture.sv
// DVP capture front end: waits for camera configuration, skips settling
// frames, then streams packed gray pixels with frame/line markers.
module dvp_frame_capture
  import dvp_pkg::*;
#(
  parameter int IMG_W       = 1280,
  parameter int IMG_H       = 720,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_done,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              frame_err,
  output logic              ovf,
  output logic [15:0]       frame_cnt
);

  if (!geometry_ok(IMG_W, IMG_H, SKIP_FRAMES)) begin : g_bad_params
    $error("dvp_frame_capture: unsupported IMG_W/IMG_H/SKIP_FRAMES");
  end

  localparam logic [PIX_CNT_W-1:0]  W_FULL     = PIX_CNT_W'(IMG_W);
  localparam logic [PIX_CNT_W-1:0]  FIRST_WORD = PIX_CNT_W'(4);
  localparam logic [LINE_CNT_W-1:0] H_FULL     = LINE_CNT_W'(IMG_H);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE  = LINE_CNT_W'(IMG_H - 1);

  logic                  vsync_s1, href_s1, vsync_q, href_q;
  logic [7:0]            d_s1;
  logic                  vs_rise, vs_fall, href_rise, href_fall;
  state_t                state;
  logic                  in_frame;
  logic [SKIP_W-1:0]     skip_cnt;
  logic [PIX_CNT_W-1:0]  pix_cnt, pix_next;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic                  capturing, take;
  logic                  line_start_err, line_end_err;
  logic                  overflow, eof_accept;
  flags_t                byte_flags;

  // vsync idles high between frames, so resetting its history high avoids a
  // phantom frame end when the sensor is already between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1 <= 1'b1;
      vsync_q  <= 1'b1;
      href_s1  <= 1'b0;
      href_q   <= 1'b0;
      d_s1     <= 8'd0;
    end else begin
      vsync_s1 <= vsync;
      href_s1  <= href;
      d_s1     <= d;
      vsync_q  <= vsync_s1;
      href_q   <= href_s1;
    end
  end

  assign vs_rise   = vsync_s1 && !vsync_q;
  assign vs_fall   = !vsync_s1 && vsync_q;
  assign href_rise = href_s1 && !href_q;
  assign href_fall = !href_s1 && href_q;

  assign line_end_err   = href_fall && (pix_cnt != W_FULL);
  assign line_start_err = href_rise && (line_cnt == H_FULL);

  // vsync edges take priority over any coincident href activity.
  assign capturing = cfg_done && (state == ACTIVE) && in_frame && !vs_rise && !vs_fall;
  assign take      = capturing && href_s1 && !line_start_err;

  assign pix_next       = pix_cnt + PIX_CNT_W'(1);
  assign byte_flags.sof = (line_cnt == '0) && (pix_next == FIRST_WORD);
  assign byte_flags.eol = (pix_next == W_FULL);
  assign byte_flags.eof = (pix_next == W_FULL) && (line_cnt == LAST_LINE);

  assign eof_accept = m_valid && m_ready && m_eof;

  dvp_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (!cfg_done),
    .sync       (vs_fall),
    .byte_valid (take),
    .byte_in    (d_s1),
    .flags      (byte_flags),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .overflow   (overflow)
  );

  // in_frame separates live capture from ACTIVE waiting for the next frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_frame  <= 1'b0;
      skip_cnt  <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      frame_err <= 1'b0;
      if (eof_accept) frame_cnt <= frame_cnt + 16'd1;
      if (!cfg_done) begin
        state     <= IDLE;
        in_frame  <= 1'b0;
        skip_cnt  <= '0;
        pix_cnt   <= '0;
        line_cnt  <= '0;
        frame_cnt <= 16'd0;
      end else begin
        unique case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vs_rise) begin
              skip_cnt <= SKIP_W'(SKIP_FRAMES);
              state    <= SKIP;
            end
          end
          SKIP: begin
            if (vs_rise) begin
              if (skip_cnt != '0) skip_cnt <= skip_cnt - SKIP_W'(1);
            end else if (vs_fall && (skip_cnt == '0)) begin
              state    <= ACTIVE;
              in_frame <= 1'b1;
              pix_cnt  <= '0;
              line_cnt <= '0;
            end
          end
          ACTIVE: begin
            if (vs_rise) begin
              in_frame <= 1'b0;
              if (in_frame && (line_cnt != H_FULL)) begin
                frame_err <= 1'b1;
                state     <= DROP;
              end
            end else if (vs_fall) begin
              in_frame <= 1'b1;
              pix_cnt  <= '0;
              line_cnt <= '0;
            end else if (in_frame) begin
              if (overflow) begin
                ovf   <= 1'b1;
                state <= DROP;
              end else if (line_end_err || line_start_err) begin
                frame_err <= 1'b1;
                state     <= DROP;
              end else if (href_fall) begin
                line_cnt <= line_cnt + LINE_CNT_W'(1);
                pix_cnt  <= '0;
              end else if (take) begin
                pix_cnt <= pix_next;
              end
            end
          end
          DROP: begin
            if (vs_fall) begin
              state    <= ACTIVE;
              in_frame <= 1'b1;
              pix_cnt  <= '0;
              line_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Scoreboard bench for dvp_frame_capture on a tiny 8x2 image with one skip frame;
// expected words are queued by the frame driver and checked by a monitor.
module tb_dvp_frame_capture;
  import dvp_pkg::*;

  localparam int IMG_W       = 8;
  localparam int IMG_H       = 2;
  localparam int SKIP_FRAMES = 1;
  localparam int WPL         = IMG_W / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  d = 8'd0;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_valid, m_sof, m_eol, m_eof, frame_err, ovf;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   valid_seen = 0;
  int   err_cycles = 0;

  always #5 clk = ~clk;

  dvp_frame_capture #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .SKIP_FRAMES (SKIP_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_done  (cfg_done),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_eof     (m_eof),
    .frame_err (frame_err),
    .ovf       (ovf),
    .frame_cnt (frame_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic vs, input logic hr, input logic [7:0] dd, input logic rdy);
    @(posedge clk);
    #1;
    vsync   = vs;
    href    = hr;
    d       = dd;
    m_ready = rdy;
  endtask

  // Bytes run contiguously from base across lines; stall/cut/reset slots are
  // counted from the first byte of line 0 (negative disables).
  task automatic send_frame(input logic [7:0] base, input int n_expect, input int short_line,
                            input int stall_at, input int cut_at, input int rst_at);
    exp_t       e;
    logic [7:0] b;
    logic       rdy;
    int         k;
    int         n;
    for (int w = 0; w < n_expect; w++) begin
      b      = base + 8'(4 * w);
      e.data = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      e.sof  = (w == 0);
      e.eol  = ((w % WPL) == WPL - 1);
      e.eof  = (w == WPL * IMG_H - 1);
      exp_q.push_back(e);
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    k = 0;
    for (int l = 0; l < IMG_H; l++) begin
      n = (l == short_line) ? IMG_W - 1 : IMG_W;
      for (int p = 0; p < IMG_W + 2; p++) begin
        rdy = !((stall_at >= 0) && (k >= stall_at) && (k < stall_at + 5));
        b   = base + 8'(l * IMG_W + p);
        if (p < n) apply_stimulus(1'b0, 1'b1, b, rdy);
        else       apply_stimulus(1'b0, 1'b0, 8'h00, rdy);
        if (k == cut_at) cfg_done = 1'b0;
        if ((cut_at >= 0) && (k == cut_at + 1)) begin
          check_output("cfg_drop_valid", {31'd0, m_valid}, 32'd0);
          check_output("cfg_drop_state", 32'(dut.state), 32'(IDLE));
        end
        if (k == rst_at) begin
          rst_n = 1'b0;
          #1;
          check_output("rst_mid_valid", {31'd0, m_valid}, 32'd0);
          check_output("rst_mid_data", m_data, 32'd0);
          check_output("rst_mid_flags", {28'd0, m_sof, m_eol, m_eof, frame_err}, 32'd0);
          check_output("rst_mid_ovf", {31'd0, ovf}, 32'd0);
          check_output("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        end
        if ((rst_at >= 0) && (k == rst_at + 1)) rst_n = 1'b1;
        k++;
      end
    end
    repeat (3) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid) valid_seen++;
      if (frame_err) err_cycles++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got %h sof=%b eol=%b eof=%b, wanted no word",
                   m_data, m_sof, m_eol, m_eof);
        end else begin
          e = exp_q.pop_front();
          check_output("word_data", m_data, e.data);
          check_output("word_flags", {29'd0, m_sof, m_eol, m_eof}, {29'd0, e.sof, e.eol, e.eof});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: bench still running, wanted completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_valid", {31'd0, m_valid}, 32'd0);
    check_output("reset_data", m_data, 32'd0);
    check_output("reset_flags", {28'd0, m_sof, m_eol, m_eof, frame_err}, 32'd0);
    check_output("reset_ovf", {31'd0, ovf}, 32'd0);
    check_output("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check_output("reset_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;

    // Unconfigured sensor: frames arrive but nothing is captured.
    repeat (3) send_frame(8'h00, 0, -1, -1, -1, -1);
    check_output("nocfg_valid_seen", 32'(valid_seen), 32'd0);
    check_output("nocfg_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // First rise arms the skip, one frame is discarded, the third is captured.
    cfg_done = 1'b1;
    send_frame(8'h00, 0, -1, -1, -1, -1);
    send_frame(8'h00, 0, -1, -1, -1, -1);
    check_output("skip_valid_seen", 32'(valid_seen), 32'd0);
    send_frame(8'h00, 4, -1, -1, -1, -1);
    check_output("frame1_cnt", {16'd0, frame_cnt}, 32'd1);
    send_frame(8'h40, 4, -1, -1, -1, -1);
    check_output("frame2_cnt", {16'd0, frame_cnt}, 32'd2);
    check_output("clean_ovf", {31'd0, ovf}, 32'd0);

    // Stall long enough for the second word to collide with the held first one.
    send_frame(8'h80, 1, -1, 4, -1, -1);
    check_output("ovf_set", {31'd0, ovf}, 32'd1);
    check_output("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    send_frame(8'h10, 4, -1, -1, -1, -1);
    check_output("ovf_recover_cnt", {16'd0, frame_cnt}, 32'd3);
    check_output("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Seven-byte first line.
    check_output("pre_err_cycles", 32'(err_cycles), 32'd0);
    send_frame(8'h20, 1, 0, -1, -1, -1);
    check_output("short_err_cycles", 32'(err_cycles), 32'd1);
    check_output("short_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    send_frame(8'h30, 4, -1, -1, -1, -1);
    check_output("short_recover_cnt", {16'd0, frame_cnt}, 32'd4);
    check_output("short_recover_err", 32'(err_cycles), 32'd1);

    // Configuration lost while a word is held, then restored.
    send_frame(8'hA0, 0, -1, 4, 6, -1);
    cfg_done = 1'b1;
    seen = valid_seen;
    send_frame(8'h00, 0, -1, -1, -1, -1);
    send_frame(8'h00, 0, -1, -1, -1, -1);
    check_output("recfg_skip_valid", 32'(valid_seen), 32'(seen));
    send_frame(8'h50, 4, -1, -1, -1, -1);

    // Asynchronous reset in the middle of a line.
    send_frame(8'hC0, 0, -1, -1, -1, 2);
    seen = valid_seen;
    send_frame(8'h00, 0, -1, -1, -1, -1);
    check_output("rst_skip_valid", 32'(valid_seen), 32'(seen));
    send_frame(8'h60, 4, -1, -1, -1, -1);
    check_output("rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    repeat (4) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvp_frame_capture.md
# dvp_frame_capture

Pixel-clock-domain capture stage directly downstream of camera configuration: stays idle until the sensor's register load reports done, then locks onto DVP frame timing (VSYNC/HREF/D[7:0]). It discards a programmable number of settling frames, packs 8-bit gray pixels four-per-word, and presents them on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers. Its output feeds the frame FIFO in front of the UDP packetizer.

## Interface
Parameters:
- IMG_W, 1280: pixels (bytes) per line; must be a multiple of 4.
- IMG_H, 720: lines per frame.
- SKIP_FRAMES, 2: complete frames discarded after cfg_done before the first output frame; 0 is legal.

Ports:
- clk  in  1  camera PCLK; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_done  in  1  camera configuration complete; level.
- vsync  in  1  DVP VSYNC; active-high, high between frames.
- href  in  1  DVP HREF; active-high, high while the line's pixels are on d.
- d  in  8  DVP pixel byte.
- m_data  out  32  packed word; first pixel of the group in [31:24], last in [7:0].
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_sof  out  1  qualifies the first word of a frame.
- m_eol  out  1  qualifies the last word of each line.
- m_eof  out  1  qualifies the last word of the frame (m_eol also high).
- frame_err  out  1  one-cycle pulse on a geometry violation.
- ovf  out  1  sticky; set on a stream overflow, cleared only by reset.
- frame_cnt  out  16  count of frames whose eof word was accepted; wraps at 16'hFFFF.

## Operation
- vsync, href and d are registered once (stage S1) before any use. Edges are detected on S1 against its previous value.
- Frame start is the vsync falling edge; frame end is the vsync rising edge. A line ends on the href falling edge.
- States:
  - IDLE: wait for cfg_done=1, then go to SYNC.
  - SYNC: wait for a vsync rising edge, load skip_cnt=SKIP_FRAMES, then go to SKIP.
  - SKIP: each vsync rising edge decrements skip_cnt. At frame start with skip_cnt==0, go to ACTIVE.
  - ACTIVE: capture pixels. A vsync rising edge returns to ACTIVE-wait; the next frame start captures again with no further skip.
  - DROP: ignore input until the next frame start, then go to ACTIVE.
- cfg_done=0 in any state forces IDLE on the next edge. m_valid and all counters clear, and ovf is retained.
- Pixel counter pix_cnt (11 bits) increments per S1 byte with href=1. Line counter line_cnt (10 bits) increments on each href falling edge. Both clear at frame start.
- Packer: a 2-bit byte index fills a 32-bit shift register. On the fourth byte the word loads into the output register.
  - m_sof is set when line_cnt==0 and this is the first word.
  - m_eol is set when pix_cnt reaches IMG_W.
  - m_eof is set when m_eol is set and line_cnt==IMG_H-1.
- Overflow: if a new word completes while m_valid=1 and m_ready=0:
  - the new word is discarded and the held word stays;
  - ovf is set and the state goes to DROP.
- Geometry errors: each pulses frame_err for one cycle and goes to DROP.
  - href falls with pix_cnt != IMG_W.
  - href rises with line_cnt == IMG_H.
  - vsync rises in ACTIVE with line_cnt != IMG_H.
- frame_cnt increments on acceptance of the m_eof word.

## Timing
- Reset values:
  - m_data=0, m_valid=0, m_sof=0, m_eol=0, m_eof=0.
  - frame_err=0, ovf=0, frame_cnt=0.
  - state=IDLE.
- Latency: edge k samples the fourth byte of a group into S1; m_valid is high after edge k+1. There is no bubble between consecutive lines.
- Handshake: m_data, m_sof, m_eol and m_eof are stable while m_valid=1 && m_ready=0.
  - m_valid drops the cycle after acceptance unless a new word loads on the same edge.
  - Accept and load on the same edge is legal and is not an overflow.
- A full line takes IMG_W cycles and yields one word per 4 cycles, so m_ready may be low for up to 3 consecutive cycles without overflow.
- A frame start during DROP resumes on that same frame.
- A vsync edge coincident with href activity is treated as a vsync event first.

## Structure
- Package dvp_pkg:
  - state enum (IDLE, SYNC, SKIP, ACTIVE, DROP);
  - WORD_W=32;
  - PIX_CNT_W=11 and LINE_CNT_W=10;
  - compile-time checks IMG_W%4==0, IMG_W<2048, IMG_H<1024.
- One sub-module, dvp_byte_packer: byte index, shift register, output register and valid/ready logic. It has a single "new byte" and "flags" input and an overflow output. The FSM, counters and edge detection stay in the top.

## Test plan
Bench setting: IMG_W=8, IMG_H=2, SKIP_FRAMES=1, unless noted.
- cfg_done=0 with three full frames driven -> m_valid never asserts and frame_cnt=0. Then assert cfg_done -> the first output frame is the third complete frame after the first vsync rise.
- One frame with d=0x00..0x0F and m_ready=1 -> four words: 0x00010203 (sof), 0x04050607 (eol), 0x08090A0B, 0x0C0D0E0F (eol, eof). Afterwards frame_cnt=1.
- m_ready=0 for 5 cycles mid-line -> ovf=1, and the held word persists until accepted. The rest of the frame produces no words; the next frame outputs fully with sof.
- Line of 7 bytes -> frame_err pulses one cycle after the href fall is detected. No eof for that frame, and the next frame is clean.
- Deassert cfg_done mid-line -> m_valid=0 within one cycle and the state is IDLE. Re-assert -> SYNC/SKIP sequence repeats.
- Async rst_n pulse mid-frame -> all outputs at reset values immediately, with no output until the full cfg_done/skip sequence completes again.
